// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings, RV32I funct3 codes and arbiter state enum
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [3:0] HPROT_FETCH = 4'b0000;
  localparam logic [3:0] HPROT_DATA  = 4'b0001;

  localparam logic [2:0] FN3_B  = 3'b000;
  localparam logic [2:0] FN3_H  = 3'b001;
  localparam logic [2:0] FN3_W  = 3'b010;
  localparam logic [2:0] FN3_BU = 3'b100;
  localparam logic [2:0] FN3_HU = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR} arb_state_e;

  function automatic logic [2:0] fn3_to_hsize(input logic [2:0] fn3);
    case (fn3)
      FN3_B, FN3_BU: return HSIZE_BYTE;
      FN3_H, FN3_HU: return HSIZE_HALF;
      default:       return HSIZE_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] alo);
    case (size)
      HSIZE_BYTE: return 1'b0;
      HSIZE_HALF: return alo[0];
      default:    return alo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ahb_port_arbiter_if.sv
// rtl/ahb_port_arbiter_if.sv - AHB-Lite master bus bundle driven by the port arbiter
interface ahb_port_arbiter_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (output haddr, htrans, hwrite, hsize, hprot, hwdata,
                  input  hrdata, hready, hresp);
  modport slave  (input  haddr, htrans, hwrite, hsize, hprot, hwdata,
                  output hrdata, hready, hresp);
endinterface

// File: rtl/ahb_load_align.sv
// rtl/ahb_load_align.sv - picks the load lane from the read word and sign/zero extends it
module ahb_load_align
  import ahb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  fn3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign shifted = rdata >> {addr_lo, 3'b000};
  assign lane_b  = shifted[7:0];
  assign lane_h  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    case (fn3)
      FN3_B:   result = {{24{lane_b[7]}}, lane_b};
      FN3_BU:  result = {24'b0, lane_b};
      FN3_H:   result = {{16{lane_h[15]}}, lane_h};
      FN3_HU:  result = {16'b0, lane_h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/ahb_port_arbiter.sv
// rtl/ahb_port_arbiter.sv - fetch/data port arbiter onto a single AHB-Lite master
module ahb_port_arbiter
  import ahb_pkg::*;
#(
  parameter logic [7:0] DATA_REGION = 8'hB0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_fn3,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic        rsp_src,
  output logic [31:0] rsp_rdata,
  ahb_port_arbiter_if.master bus
);

  arb_state_e  state, state_n;
  logic [31:0] haddr_q, haddr_n, hwdata_q, hwdata_n;
  logic [1:0]  htrans_q, htrans_n;
  logic        hwrite_q, hwrite_n;
  logic [2:0]  hsize_q, hsize_n;
  logic [3:0]  hprot_q, hprot_n;
  logic        rsp_valid_n, rsp_err_n, rsp_src_n;
  logic [31:0] rsp_rdata_n;
  logic        owner, owner_n;
  logic [2:0]  cap_fn3, fn3_n;
  logic [1:0]  cap_alo, alo_n;
  logic [31:0] cap_wdata, wdata_n;
  logic [2:0]  sel_size;
  logic [1:0]  sel_alo;
  logic        sel_mis;
  logic [31:0] sel_wdata, load_data;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^d_addr[31:24];

  assign sel_size  = d_req ? fn3_to_hsize(d_fn3) : HSIZE_WORD;
  assign sel_alo   = d_req ? d_addr[1:0] : if_addr[1:0];
  assign sel_mis   = is_misaligned(sel_size, sel_alo);
  assign sel_wdata = (sel_size == HSIZE_BYTE) ? {4{d_wdata[7:0]}} :
                     (sel_size == HSIZE_HALF) ? {2{d_wdata[15:0]}} : d_wdata;

  ahb_load_align u_align (
    .rdata   (bus.hrdata),
    .fn3     (cap_fn3),
    .addr_lo (cap_alo),
    .result  (load_data)
  );

  always_comb begin
    state_n     = state;
    haddr_n     = haddr_q;
    htrans_n    = htrans_q;
    hwrite_n    = hwrite_q;
    hsize_n     = hsize_q;
    hprot_n     = hprot_q;
    hwdata_n    = hwdata_q;
    rsp_valid_n = 1'b0;
    rsp_err_n   = 1'b0;
    rsp_src_n   = rsp_src;
    rsp_rdata_n = rsp_rdata;
    owner_n     = owner;
    fn3_n       = cap_fn3;
    alo_n       = cap_alo;
    wdata_n     = cap_wdata;
    case (state)
      // rsp_valid high marks the turnaround cycle, so requests are ignored then
      ST_IDLE: if (!rsp_valid && (d_req || if_req)) begin
        owner_n = d_req;
        if (sel_mis) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_src_n   = d_req;
          rsp_rdata_n = '0;
        end else begin
          state_n  = ST_ADDR;
          htrans_n = HTRANS_NONSEQ;
          haddr_n  = d_req ? {DATA_REGION, d_addr[23:0]} : if_addr;
          hwrite_n = d_req & d_we;
          hsize_n  = sel_size;
          hprot_n  = d_req ? HPROT_DATA : HPROT_FETCH;
          fn3_n    = d_req ? d_fn3 : FN3_W;
          alo_n    = sel_alo;
          wdata_n  = sel_wdata;
        end
      end
      ST_ADDR: if (bus.hready) begin
        state_n  = ST_DATA;
        htrans_n = HTRANS_IDLE;
        if (hwrite_q) hwdata_n = cap_wdata;
      end
      ST_DATA: if (bus.hready) begin
        state_n     = ST_IDLE;
        rsp_valid_n = 1'b1;
        rsp_err_n   = bus.hresp;
        rsp_src_n   = owner;
        rsp_rdata_n = bus.hresp ? '0 : load_data;
      end else if (bus.hresp) begin
        state_n = ST_ERR;
      end
      ST_ERR: if (bus.hready) begin
        state_n     = ST_IDLE;
        rsp_valid_n = 1'b1;
        rsp_err_n   = 1'b1;
        rsp_src_n   = owner;
        rsp_rdata_n = '0;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      haddr_q   <= '0;
      htrans_q  <= HTRANS_IDLE;
      hwrite_q  <= 1'b0;
      hsize_q   <= HSIZE_WORD;
      hprot_q   <= HPROT_FETCH;
      hwdata_q  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_src   <= 1'b0;
      rsp_rdata <= '0;
      owner     <= 1'b0;
      cap_fn3   <= FN3_W;
      cap_alo   <= '0;
      cap_wdata <= '0;
    end else begin
      state     <= state_n;
      haddr_q   <= haddr_n;
      htrans_q  <= htrans_n;
      hwrite_q  <= hwrite_n;
      hsize_q   <= hsize_n;
      hprot_q   <= hprot_n;
      hwdata_q  <= hwdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_src   <= rsp_src_n;
      rsp_rdata <= rsp_rdata_n;
      owner     <= owner_n;
      cap_fn3   <= fn3_n;
      cap_alo   <= alo_n;
      cap_wdata <= wdata_n;
    end
  end

  assign bus.haddr  = haddr_q;
  assign bus.htrans = htrans_q;
  assign bus.hwrite = hwrite_q;
  assign bus.hsize  = hsize_q;
  assign bus.hprot  = hprot_q;
  assign bus.hwdata = hwdata_q;

endmodule

// File: tb/tb_ahb_port_arbiter.sv
// tb/tb_ahb_port_arbiter.sv - transaction-level model bench for ahb_port_arbiter
module tb_ahb_port_arbiter;

  localparam logic [7:0] REGION = 8'hB0;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  fn3;
    int          aw, dw, ew, mode;
    logic [31:0] rdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [2:0]  d_fn3;
  logic        rsp_valid, rsp_err, rsp_src;
  logic [31:0] rsp_rdata;

  ahb_port_arbiter_if bus();

  ahb_port_arbiter #(.DATA_REGION(REGION)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_fn3(d_fn3),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_src(rsp_src), .rsp_rdata(rsp_rdata),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  bit          chk_en = 0;
  logic [1:0]  e_htrans;
  bit          e_addr_chk, e_wd_chk, e_rv, e_err, e_src;
  logic [31:0] e_haddr, e_hwdata, e_rdata;
  logic [2:0]  e_hsize;
  logic        e_hwrite;
  logic [3:0]  e_hprot;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---- behavioural model ----
  function automatic int m_bytes(input txn_t t);
    if (!t.is_d) return 4;
    if (t.fn3 == 3'd0 || t.fn3 == 3'd4) return 1;
    if (t.fn3 == 3'd1 || t.fn3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit m_misaligned(input txn_t t);
    return (int'(t.addr[1:0]) % m_bytes(t)) != 0;
  endfunction

  function automatic logic [2:0] m_hsize(input txn_t t);
    int b = m_bytes(t);
    return (b == 1) ? 3'd0 : (b == 2) ? 3'd1 : 3'd2;
  endfunction

  function automatic logic [31:0] m_haddr(input txn_t t);
    return t.is_d ? ({24'b0, REGION} << 24) | (t.addr & 32'h00FF_FFFF) : t.addr;
  endfunction

  function automatic logic [31:0] m_hwdata(input txn_t t);
    int b = m_bytes(t);
    logic [31:0] pat, r;
    if (b == 4) return t.wdata;
    pat = t.wdata & ((32'd1 << (8 * b)) - 32'd1);
    r = 0;
    for (int k = 0; k < 4 / b; k++) r = r | (pat << (8 * b * k));
    return r;
  endfunction

  function automatic logic [31:0] m_load(input txn_t t);
    int b = m_bytes(t);
    int off;
    logic [31:0] v, mask;
    if (b == 4) return t.rdata;
    off  = int'(t.addr[1:0]) / b * b;
    mask = (b == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v    = (t.rdata >> (8 * off)) & mask;
    if (t.fn3 < 3'd4 && v > (mask >> 1)) v = v | ~mask;
    return v;
  endfunction

  // ---- single per-cycle compare process ----
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("htrans", 32'(bus.htrans), 32'(e_htrans));
      cmp("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      cmp("rsp_rdata", rsp_rdata, e_rdata);
      if (e_rv) begin
        cmp("rsp_err", 32'(rsp_err), 32'(e_err));
        cmp("rsp_src", 32'(rsp_src), 32'(e_src));
      end
      if (e_addr_chk) begin
        cmp("haddr", bus.haddr, e_haddr);
        cmp("hsize", 32'(bus.hsize), 32'(e_hsize));
        cmp("hwrite", 32'(bus.hwrite), 32'(e_hwrite));
        cmp("hprot", 32'(bus.hprot), 32'(e_hprot));
      end
      if (e_wd_chk) cmp("hwdata", bus.hwdata, e_hwdata);
    end
  end

  // ---- stimulus ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle();
    e_htrans = 2'b00; e_rv = 0; e_addr_chk = 0; e_wd_chk = 0;
  endtask

  task automatic exp_addr(input txn_t t);
    exp_idle();
    e_htrans = 2'b10; e_addr_chk = 1;
    e_haddr = m_haddr(t); e_hsize = m_hsize(t);
    e_hwrite = t.is_d & t.we; e_hprot = t.is_d ? 4'b0001 : 4'b0000;
  endtask

  task automatic exp_data(input txn_t t);
    exp_idle();
    e_wd_chk = t.is_d & t.we;
    e_hwdata = m_hwdata(t);
  endtask

  task automatic exp_done(input txn_t t, input bit err);
    exp_idle();
    e_rv = 1; e_err = err; e_src = t.is_d;
    e_rdata = err ? 32'h0 : m_load(t);
  endtask

  task automatic present(input txn_t t);
    if (t.is_d) begin
      d_req = 1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata; d_fn3 = t.fn3;
    end else begin
      if_req = 1; if_addr = t.addr;
    end
  endtask

  task automatic drop(input txn_t t, input bit keep_if);
    if (t.is_d) d_req = 0;
    else if (!keep_if) if_req = 0;
  endtask

  // Caller has presented the request so that the next edge is the grant edge.
  task automatic do_txn(input txn_t t, input bit keep_if);
    step();
    if (m_misaligned(t)) begin
      exp_done(t, 1);
      drop(t, keep_if);
    end else begin
      for (int i = 0; i <= t.aw; i++) begin
        if (i > 0) step();
        exp_addr(t);
        bus.hready = (i == t.aw);
        bus.hresp  = 1'($urandom % 2);
      end
      for (int i = 0; i <= t.dw; i++) begin
        step();
        exp_data(t);
        bus.hrdata = t.rdata;
        bus.hready = 0; bus.hresp = 0;
        if (i == t.dw) begin
          bus.hready = (t.mode != 2);
          bus.hresp  = (t.mode != 0);
        end
      end
      if (t.mode == 2) begin
        for (int i = 0; i <= t.ew; i++) begin
          step();
          exp_data(t);
          bus.hready = (i == t.ew); bus.hresp = 1;
        end
      end
      step();
      exp_done(t, t.mode != 0);
      drop(t, keep_if);
      bus.hready = 1; bus.hresp = 0;
    end
    step();
    exp_idle();
  endtask

  function automatic txn_t mk(input bit is_d, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] fn3,
                              input int aw, input int dw, input int ew, input int mode,
                              input logic [31:0] rdata);
    txn_t t;
    t.is_d = is_d; t.we = we; t.addr = addr; t.wdata = wdata; t.fn3 = fn3;
    t.aw = aw; t.dw = dw; t.ew = ew; t.mode = mode; t.rdata = rdata;
    return t;
  endfunction

  function automatic txn_t rnd_txn(input bit is_d);
    txn_t t;
    int r = int'($urandom % 8);
    t = mk(is_d, is_d ? 1'($urandom % 2) : 1'b0, $urandom, $urandom, 3'($urandom % 8),
           int'($urandom % 3), int'($urandom % 3), int'($urandom % 3),
           (r < 6) ? 0 : (r == 6) ? 1 : 2, $urandom);
    if ($urandom % 3 != 0) t.addr[1:0] = 2'b00;
    return t;
  endfunction

  initial begin
    txn_t t, f;
    reset = 1; if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0; d_fn3 = 0;
    bus.hrdata = 0; bus.hready = 1; bus.hresp = 0;
    e_rdata = 0; exp_idle();
    repeat (3) step();
    cmp("rst_htrans", 32'(bus.htrans), 32'h0);
    cmp("rst_hsize", 32'(bus.hsize), 32'h2);
    cmp("rst_haddr", bus.haddr, 32'h0);
    cmp("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    reset = 0;
    chk_en = 1;
    step();

    // signed byte load, zero waits
    t = mk(1, 0, 32'h0000_1003, 0, 3'b000, 0, 0, 0, 0, 32'h8000_0000);
    cmp("pin_haddr", m_haddr(t), 32'hB000_1003);
    cmp("pin_lb", m_load(t), 32'hFFFF_FF80);
    present(t); do_txn(t, 0);
    cmp("lb_rdata_held", rsp_rdata, 32'hFFFF_FF80);

    // both requesters: data store wins, fetch follows the turnaround
    t = mk(1, 1, 32'h0000_0020, 32'h1234_5678, 3'b010, 0, 0, 0, 0, 0);
    f = mk(0, 0, 32'h0000_0200, 0, 0, 0, 0, 0, 0, 32'h0BAD_CAFE);
    cmp("pin_sw", m_hwdata(t), 32'h1234_5678);
    present(t); present(f);
    do_txn(t, 1); do_txn(f, 0);

    // fetch with wait states in both phases
    t = mk(0, 0, 32'h0000_0100, 0, 0, 2, 1, 0, 0, 32'hCAFE_F00D);
    present(t); do_txn(t, 0);
    cmp("fetch_rdata_held", rsp_rdata, 32'hCAFE_F00D);

    // two-cycle error response
    t = mk(1, 0, 32'h0000_0080, 0, 3'b010, 0, 0, 0, 2, 32'hDEAD_BEEF);
    present(t); do_txn(t, 0);
    cmp("err_rdata", rsp_rdata, 32'h0);

    // misaligned half load and misaligned fetch
    t = mk(1, 0, 32'h0000_0001, 0, 3'b001, 0, 0, 0, 0, 0);
    cmp("pin_mis", 32'(m_misaligned(t)), 32'h1);
    present(t); do_txn(t, 0);
    t = mk(0, 0, 32'h0000_0102, 0, 0, 0, 0, 0, 0, 0);
    present(t); do_txn(t, 0);

    // reset in DATA while completion is due
    t = mk(1, 0, 32'h0000_0040, 0, 3'b010, 0, 0, 0, 0, 32'h5555_AAAA);
    present(t);
    step(); exp_addr(t); bus.hready = 1;
    step(); exp_data(t); bus.hrdata = t.rdata; bus.hready = 1; bus.hresp = 0; reset = 1;
    step(); chk_en = 0;
    cmp("rstdata_htrans", 32'(bus.htrans), 32'h0);
    cmp("rstdata_rsp_valid", 32'(rsp_valid), 32'h0);
    cmp("rstdata_hprot", 32'(bus.hprot), 32'h0);
    cmp("rstdata_hsize", 32'(bus.hsize), 32'h2);
    reset = 0; d_req = 0; e_rdata = 0; exp_idle(); chk_en = 1;
    step();

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      int kind = int'($urandom % 3);
      if (kind == 2) begin
        t = rnd_txn(1); f = rnd_txn(0);
        present(t); present(f);
        do_txn(t, 1); do_txn(f, 0);
      end else begin
        t = rnd_txn(kind == 1);
        present(t); do_txn(t, 0);
      end
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
